// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared types and constants for the reorder buffer; register_status reuses
// ROB_DEPTH / ROB_TAG_W so its reorder_addr field stays in step with the ROB.
//   rob_state_e  : FREE / PENDING / DONE per-entry state
//   rob_entry_s  : one buffer entry (state, destination, result)
//   rob_lookup_s : result of an operand lookup (ready flag + value)
//   rob_lookup() : operand lookup rule shared by both issue-stage read ports
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_TAG_W = 4;
   localparam int ROB_XLEN  = 32;

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      PENDING = 2'd1,
      DONE    = 2'd2
   } rob_state_e;

   typedef struct packed {
      rob_state_e          state;
      logic [4:0]          rd_addr;
      logic                wr_en;
      logic [ROB_XLEN-1:0] value;
   } rob_entry_s;

   typedef struct packed {
      logic                ready;
      logic [ROB_XLEN-1:0] value;
   } rob_lookup_s;

   // A result on the CDB this cycle is forwarded to a still-PENDING entry, so
   // a renamed source never waits an extra cycle for the stored copy.
   function automatic rob_lookup_s rob_lookup(input rob_entry_s          entry,
                                              input logic                cdb_hit,
                                              input logic [ROB_XLEN-1:0] cdb_value);
      rob_lookup_s res;
      res = '0;
      if (cdb_hit && entry.state == PENDING) begin
         res.ready = 1'b1;
         res.value = cdb_value;
      end else if (entry.state == DONE) begin
         res.ready = 1'b1;
         res.value = entry.value;
      end
      return res;
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular reorder buffer for the Tomasulo core. Allocates the tail tag at
// issue, captures results from the CDB, retires the head in program order and
// answers two operand lookups for the issue stage.
// Ports:
//   clk_i, reset_i                    clock, async active-high reset
//   issue_valid_i/_ready_o/_tag_o     allocation handshake and granted tag
//   issue_wr_en_i, issue_rd_addr_i    destination of the issuing instruction
//   cdb_valid_i/_tag_i/_value_i       result broadcast
//   rd_tag{1,2}_i, rd_ready{1,2}_o,
//   rd_value{1,2}_o                   combinational operand lookups
//   commit_*_o                        combinational retire port to register_status
//   flush_i                           squash everything (mispredict)
//   count_o, empty_o, full_o          occupancy
// XLEN must equal ROB_XLEN, since entries are stored as rob_entry_s.
// -----------------------------------------------------------------------------
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = ROB_TAG_W,
   parameter int XLEN  = ROB_XLEN
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             issue_valid_i,
   output logic             issue_ready_o,
   input  logic             issue_wr_en_i,
   input  logic [4:0]       issue_rd_addr_i,
   output logic [TAG_W-1:0] issue_tag_o,
   input  logic             cdb_valid_i,
   input  logic [TAG_W-1:0] cdb_tag_i,
   input  logic [XLEN-1:0]  cdb_value_i,
   input  logic [TAG_W-1:0] rd_tag1_i,
   input  logic [TAG_W-1:0] rd_tag2_i,
   output logic             rd_ready1_o,
   output logic             rd_ready2_o,
   output logic [XLEN-1:0]  rd_value1_o,
   output logic [XLEN-1:0]  rd_value2_o,
   output logic             commit_wr_en_o,
   output logic             commit_valid_o,
   output logic [4:0]       commit_wr_addr_o,
   output logic [TAG_W-1:0] commit_reorder_addr_o,
   output logic [XLEN-1:0]  commit_value_o,
   input  logic             flush_i,
   output logic [TAG_W:0]   count_o,
   output logic             empty_o,
   output logic             full_o
);

   rob_entry_s       entry_q [DEPTH];
   logic [TAG_W-1:0] head_q;
   logic [TAG_W-1:0] tail_q;
   logic [TAG_W:0]   count_q;

   rob_entry_s       head_entry;
   rob_lookup_s      lookup1;
   rob_lookup_s      lookup2;
   logic             do_issue;
   logic             do_cdb;
   logic             do_commit;

   assign empty_o       = (count_q == '0);
   assign full_o        = (count_q == (TAG_W+1)'(DEPTH));
   assign issue_ready_o = !full_o;
   assign issue_tag_o   = tail_q;
   assign count_o       = count_q;
   assign head_entry    = entry_q[head_q];

   // Full blocks issue even when the head retires this cycle: no pass-through.
   assign do_issue  = issue_valid_i && !full_o;
   assign do_cdb    = cdb_valid_i && (entry_q[cdb_tag_i].state == PENDING);
   assign do_commit = !empty_o && (head_entry.state == DONE) && !flush_i;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      commit_valid_o        = 1'b0;
      commit_wr_en_o        = 1'b0;
      commit_wr_addr_o      = '0;
      commit_reorder_addr_o = '0;
      commit_value_o        = '0;
      if (do_commit) begin
         commit_valid_o        = 1'b1;
         commit_wr_en_o        = head_entry.wr_en && (head_entry.rd_addr != 5'd0);
         commit_wr_addr_o      = head_entry.rd_addr;
         commit_reorder_addr_o = head_q;
         commit_value_o        = head_entry.value;
      end
   end

   assign lookup1     = rob_lookup(entry_q[rd_tag1_i], cdb_valid_i && (cdb_tag_i == rd_tag1_i),
                                   cdb_value_i);
   assign lookup2     = rob_lookup(entry_q[rd_tag2_i], cdb_valid_i && (cdb_tag_i == rd_tag2_i),
                                   cdb_value_i);
   assign rd_ready1_o = lookup1.ready;
   assign rd_value1_o = lookup1.value;
   assign rd_ready2_o = lookup2.ready;
   assign rd_value2_o = lookup2.value;

   // Issue (tail, FREE), CDB (a PENDING entry) and commit (head, DONE) always
   // target different entries, so their updates never collide.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         // NOTE: the entry array is reset in full: state must read FREE straight
         // out of reset, and clearing the payload keeps stale data off the ports.
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every update here sees the
         // pre-edge state, exactly as the flops will.
         if (do_commit) begin
            entry_q[head_q] <= '0;
            head_q          <= head_q + TAG_W'(1);
         end
         if (do_cdb) begin
            entry_q[cdb_tag_i].state <= DONE;
            entry_q[cdb_tag_i].value <= cdb_value_i;
         end
         if (do_issue) begin
            entry_q[tail_q] <= '{state: PENDING, rd_addr: issue_rd_addr_i,
                                 wr_en: issue_wr_en_i, value: '0};
            tail_q          <= tail_q + TAG_W'(1);
         end
         case ({do_issue, do_commit})
            2'b10:   count_q <= count_q + (TAG_W+1)'(1);
            2'b01:   count_q <= count_q - (TAG_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Self-checking bench: the ROB is modelled as a program-order queue of live
// instructions, each remembering its tag. A negedge process compares every
// DUT output against that model each cycle, then advances the model; directed
// sequences add literal expectations at chosen points.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        issue_valid_i;
   logic        issue_ready_o;
   logic        issue_wr_en_i;
   logic [4:0]  issue_rd_addr_i;
   logic [3:0]  issue_tag_o;
   logic        cdb_valid_i;
   logic [3:0]  cdb_tag_i;
   logic [31:0] cdb_value_i;
   logic [3:0]  rd_tag1_i;
   logic [3:0]  rd_tag2_i;
   logic        rd_ready1_o;
   logic        rd_ready2_o;
   logic [31:0] rd_value1_o;
   logic [31:0] rd_value2_o;
   logic        commit_wr_en_o;
   logic        commit_valid_o;
   logic [4:0]  commit_wr_addr_o;
   logic [3:0]  commit_reorder_addr_o;
   logic [31:0] commit_value_o;
   logic        flush_i;
   logic [4:0]  count_o;
   logic        empty_o;
   logic        full_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   reorder_buffer dut (
      .clk_i                 (clk_i),
      .reset_i               (reset_i),
      .issue_valid_i         (issue_valid_i),
      .issue_ready_o         (issue_ready_o),
      .issue_wr_en_i         (issue_wr_en_i),
      .issue_rd_addr_i       (issue_rd_addr_i),
      .issue_tag_o           (issue_tag_o),
      .cdb_valid_i           (cdb_valid_i),
      .cdb_tag_i             (cdb_tag_i),
      .cdb_value_i           (cdb_value_i),
      .rd_tag1_i             (rd_tag1_i),
      .rd_tag2_i             (rd_tag2_i),
      .rd_ready1_o           (rd_ready1_o),
      .rd_ready2_o           (rd_ready2_o),
      .rd_value1_o           (rd_value1_o),
      .rd_value2_o           (rd_value2_o),
      .commit_wr_en_o        (commit_wr_en_o),
      .commit_valid_o        (commit_valid_o),
      .commit_wr_addr_o      (commit_wr_addr_o),
      .commit_reorder_addr_o (commit_reorder_addr_o),
      .commit_value_o        (commit_value_o),
      .flush_i               (flush_i),
      .count_o               (count_o),
      .empty_o               (empty_o),
      .full_o                (full_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: live instructions in program order
   typedef struct {
      int          tag;
      logic [4:0]  rd;
      logic        wr;
      logic        done;
      logic [31:0] value;
   } m_ent_t;

   m_ent_t m_q[$];
   int     m_next_tag = 0;

   function automatic int m_find(input int tag);
      for (int k = 0; k < m_q.size(); k++)
         if (m_q[k].tag == tag) return k;
      return -1;
   endfunction

   task automatic m_lookup(input int tag, output logic rdy, output logic [31:0] val);
      int k;
      k   = m_find(tag);
      rdy = 1'b0;
      val = '0;
      if (k >= 0) begin
         if (!m_q[k].done && cdb_valid_i && int'(cdb_tag_i) == tag) begin
            rdy = 1'b1;
            val = cdb_value_i;
         end else if (m_q[k].done) begin
            rdy = 1'b1;
            val = m_q[k].value;
         end
      end
   endtask

   // ---------------- compare process
   always @(negedge clk_i) begin
      int          n;
      int          k;
      logic        ev;
      logic        take_issue;
      logic        r;
      logic [31:0] v;
      m_ent_t      e;

      if (reset_i) begin
         m_q.delete();
         m_next_tag = 0;
      end
      n = m_q.size();
      check("count", count_o, n);
      check("empty", empty_o, n == 0);
      check("full", full_o, n == 16);
      check("issue_ready", issue_ready_o, n < 16);
      check("issue_tag", issue_tag_o, m_next_tag);

      ev = !reset_i && (n > 0) && m_q[0].done && !flush_i;
      check("commit_valid", commit_valid_o, ev);
      check("commit_wr_en", commit_wr_en_o, ev && m_q[0].wr && (m_q[0].rd != 5'd0));
      if (ev) begin
         check("commit_wr_addr", commit_wr_addr_o, m_q[0].rd);
         check("commit_tag", commit_reorder_addr_o, m_q[0].tag);
         check("commit_value", commit_value_o, m_q[0].value);
      end else if (flush_i || reset_i) begin
         check("commit_wr_addr_zero", commit_wr_addr_o, 0);
         check("commit_tag_zero", commit_reorder_addr_o, 0);
         check("commit_value_zero", commit_value_o, 0);
      end

      m_lookup(rd_tag1_i, r, v);
      check("rd_ready1", rd_ready1_o, r);
      check("rd_value1", rd_value1_o, v);
      m_lookup(rd_tag2_i, r, v);
      check("rd_ready2", rd_ready2_o, r);
      check("rd_value2", rd_value2_o, v);

      // advance the model by what the coming edge does
      if (!reset_i) begin
         if (flush_i) begin
            m_q.delete();
            m_next_tag = 0;
         end else begin
            take_issue = issue_valid_i && (n < 16);
            if (cdb_valid_i) begin
               k = m_find(cdb_tag_i);
               if (k >= 0 && !m_q[k].done) begin
                  m_q[k].done  = 1'b1;
                  m_q[k].value = cdb_value_i;
               end
            end
            if (ev) void'(m_q.pop_front());
            if (take_issue) begin
               e.tag   = m_next_tag;
               e.rd    = issue_rd_addr_i;
               e.wr    = issue_wr_en_i;
               e.done  = 1'b0;
               e.value = '0;
               m_q.push_back(e);
               m_next_tag = (m_next_tag + 1) % 16;
            end
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic drive(input logic iv, input logic [4:0] rd, input logic we,
                        input logic cv, input logic [3:0] ct, input logic [31:0] cval,
                        input logic fl);
      issue_valid_i   = iv;
      issue_rd_addr_i = rd;
      issue_wr_en_i   = we;
      cdb_valid_i     = cv;
      cdb_tag_i       = ct;
      cdb_value_i     = cval;
      flush_i         = fl;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_flush();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
      tick();
   endtask

   task automatic issue(input logic [4:0] rd, input logic we);
      drive(1'b1, rd, we, 1'b0, 4'd0, 32'd0, 1'b0);
      tick();
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] v);
      drive(1'b0, 5'd0, 1'b0, 1'b1, t, v, 1'b0);
      tick();
   endtask

   // ---------------- directed sequences
   initial begin
      reset_i   = 1'b1;
      rd_tag1_i = 4'd0;
      rd_tag2_i = 4'd0;
      idle();
      repeat (2) tick();
      reset_i = 1'b0;
      tick();

      // reset state
      check("rst issue_ready", issue_ready_o, 1);
      check("rst empty", empty_o, 1);
      check("rst full", full_o, 0);
      check("rst count", count_o, 0);
      check("rst issue_tag", issue_tag_o, 0);
      check("rst commit_valid", commit_valid_o, 0);
      check("rst rd_ready1", rd_ready1_o, 0);

      // single instruction: issue x5, CDB, commit
      drive(1'b1, 5'd5, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
      #1 check("first tag", issue_tag_o, 0);
      tick();
      cdb(4'd0, 32'h1234);
      idle();
      #1;
      check("t1 commit_valid", commit_valid_o, 1);
      check("t1 commit_wr_en", commit_wr_en_o, 1);
      check("t1 commit_addr", commit_wr_addr_o, 5);
      check("t1 commit_value", commit_value_o, 32'h1234);
      tick();
      check("t1 empty after", empty_o, 1);

      // fill to 16, blocked 17th, wrap
      do_flush();
      for (int i = 0; i < 16; i++) issue(5'(i + 1), 1'b1);
      drive(1'b1, 5'd20, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
      #1;
      check("fill full", full_o, 1);
      check("fill count", count_o, 16);
      check("fill ready", issue_ready_o, 0);
      tick();
      check("17th ignored count", count_o, 16);
      cdb(4'd0, 32'h500);
      drive(1'b1, 5'd21, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
      #1 check("commit while full", commit_valid_o, 1);
      tick();
      check("full blocks issue", count_o, 15);
      drive(1'b1, 5'd22, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
      #1 check("wrap tag", issue_tag_o, 0);
      tick();
      check("refull", full_o, 1);

      // out-of-order completion
      do_flush();
      issue(5'd1, 1'b1);
      issue(5'd2, 1'b1);
      issue(5'd3, 1'b1);
      cdb(4'd2, 32'h22);
      cdb(4'd1, 32'h11);
      idle();
      #1 check("ooo no commit", commit_valid_o, 0);
      cdb(4'd0, 32'h00);
      idle();
      #1 check("ooo c0 tag", commit_reorder_addr_o, 0);
      tick();
      check("ooo c1 value", commit_value_o, 32'h11);
      tick();
      check("ooo c2 addr", commit_wr_addr_o, 3);
      tick();
      check("ooo empty", empty_o, 1);

      // lookups: bypass, pending, stored, CDB to DONE ignored
      do_flush();
      for (int i = 0; i < 4; i++) issue(5'(i + 8), 1'b1);
      rd_tag1_i = 4'd3;
      rd_tag2_i = 4'd2;
      drive(1'b0, 5'd0, 1'b0, 1'b1, 4'd3, 32'hAA, 1'b0);
      #1;
      check("bypass ready", rd_ready1_o, 1);
      check("bypass value", rd_value1_o, 32'hAA);
      check("pending not ready", rd_ready2_o, 0);
      tick();
      cdb(4'd3, 32'hBB);
      idle();
      #1 check("done not overwritten", rd_value1_o, 32'hAA);
      rd_tag1_i = 4'd0;
      rd_tag2_i = 4'd0;

      // destination x0 and no-write entries
      do_flush();
      issue(5'd0, 1'b1);
      issue(5'd7, 1'b0);
      cdb(4'd0, 32'h5);
      cdb(4'd1, 32'h6);
      idle();
      #1;
      check("x0 valid", commit_valid_o, 1);
      check("x0 wr_en", commit_wr_en_o, 0);
      tick();
      check("nowr wr_en", commit_wr_en_o, 0);
      tick();

      // flush with live entries, DONE head, concurrent issue and CDB
      do_flush();
      for (int i = 0; i < 5; i++) issue(5'(i + 1), 1'b1);
      cdb(4'd0, 32'h77);
      drive(1'b1, 5'd9, 1'b1, 1'b1, 4'd1, 32'h88, 1'b1);
      #1;
      check("flush commit_valid", commit_valid_o, 0);
      check("flush commit_value", commit_value_o, 0);
      tick();
      idle();
      #1;
      check("flush count", count_o, 0);
      check("flush empty", empty_o, 1);
      check("flush tag", issue_tag_o, 0);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) issue(5'(i + 4), 1'b1);
      cdb(4'd0, 32'h99);
      idle();
      #1 check("pre-reset count", count_o, 3);
      reset_i = 1'b1;
      #1;
      check("areset count", count_o, 0);
      check("areset empty", empty_o, 1);
      check("areset commit", commit_valid_o, 0);
      check("areset rd_ready1", rd_ready1_o, 0);
      check("areset tag", issue_tag_o, 0);
      tick();
      reset_i = 1'b0;
      tick();
      drive(1'b1, 5'd3, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
      #1 check("post-reset tag", issue_tag_o, 0);
      tick();
      idle();
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
